// File: rtl/serial_adder_pkg.sv
// =====================================================================
// serial_adder_pkg: shared state encoding and sizing for the serial adder
// Rev 1.0
// =====================================================================
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  // Bit-counter width for an arbitrary operand width (always at least 1 bit).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_full_adder_bit.sv
// =====================================================================
// serial_full_adder_bit: combinational 1-bit full adder shared by all bit positions
// Rev 1.0
// =====================================================================
`default_nettype none

module serial_full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic carryin,
  output logic sum,
  output logic carryout
);

  logic half;

  assign half     = a ^ b;
  assign sum      = half ^ carryin;
  assign carryout = (a & b) | (carryin & half);

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// =====================================================================
// serial_adder_ctrl: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
// Optional signed overflow flag: define SERIAL_ADDER_OVERFLOW_EN.   Rev 1.0
// =====================================================================
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             step;
  logic             last_bit;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] result_next;

  serial_full_adder_bit u_fa (
    .a        (op_a[0]),
    .b        (op_b[0]),
    .carryin  (carry),
    .sum      (fa_sum),
    .carryout (fa_cout)
  );

  // Result fills from the top so that after WIDTH shifts bit 0 sits at the LSB.
  assign result_next = {fa_sum, result[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (count == LAST) begin
          last_bit   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      count    <= '0;
      result   <= '0;
      sum      <= '0;
      carryout <= 1'b0;
    end else if (accept) begin
      op_a   <= a;
      op_b   <= b;
      carry  <= carryin;
      count  <= '0;
      result <= '0;
    end else if (step) begin
      op_a   <= op_a >> 1;
      op_b   <= op_b >> 1;
      carry  <= fa_cout;
      count  <= count + 1'b1;
      result <= result_next;
      if (last_bit) begin
        sum      <= result_next;
        carryout <= fa_cout;
      end
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic overflow_q;

  // On the last bit, carry holds the carry into the MSB and fa_cout the carry out of it.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (last_bit) begin
      overflow_q <= carry ^ fa_cout;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// =====================================================================
// tb_serial_adder_ctrl: directed and randomized checks of serial_adder_ctrl
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carryin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .carryin  (carryin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: an accepted request yields the exact sum a+b+carryin,
  // published WIDTH edges after acceptance; busy while the count is nonzero.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W:0]   m_pend = '0;
  logic         m_pend_ov = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_co = 1'b0;
  logic         m_ov = 1'b0;
  logic [W:0]   full;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carryin};

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_co   <= 1'b0;
      m_ov   <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_sum <= m_pend[W-1:0];
        m_co  <= m_pend[W];
        m_ov  <= OVF_EN & m_pend_ov;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend    <= full;
        m_pend_ov <= (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        m_left    <= W;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("sum", 32'(sum), 32'(m_sum));
      chk("carryout", 32'(carryout), 32'(m_co));
      chk("overflow", 32'(overflow), 32'(m_ov));
    end
  end

  // Issue one request from idle and wait (bounded) for its done pulse.
  task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output int lat, output int nbusy);
    start = 1'b1; a = xa; b = xb; carryin = xc;
    lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      start = 1'b0; a = W'($urandom); b = W'($urandom); carryin = 1'($urandom);
    end while (!done && lat < 40);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  int lat, nb, nd, t1, t2, cyc;
  logic [W-1:0] s1, s2;

  initial begin
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(carryout), 32'd0);
    chk("rst_ov", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_add(8'h0F, 8'h01, 1'b0, lat, nb);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_busy_cycles", 32'(nb), 32'd8);
    chk("t1_sum", 32'(sum), 32'h10);
    chk("t1_co", 32'(carryout), 32'd0);
    @(negedge clk);

    run_add(8'hFF, 8'h01, 1'b0, lat, nb);
    chk("t2_sum", 32'(sum), 32'h00);
    chk("t2_co", 32'(carryout), 32'd1);
    chk("t2_ov", 32'(overflow), 32'd0);
    @(negedge clk);

    run_add(8'hFF, 8'hFF, 1'b1, lat, nb);
    chk("t3_sum", 32'(sum), 32'hFF);
    chk("t3_co", 32'(carryout), 32'd1);
    @(negedge clk);

    run_add(8'h7F, 8'h01, 1'b0, lat, nb);
    chk("t4_sum", 32'(sum), 32'h80);
    chk("t4_co", 32'(carryout), 32'd0);
    chk("t4_ov", 32'(overflow), 32'(OVF_EN));
    @(negedge clk);

    // Start re-pulsed with new operands in the third RUN cycle is ignored.
    start = 1'b1; a = 8'h11; b = 8'h22; carryin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h66;
    @(negedge clk);
    start = 1'b0;
    nd = 0; s1 = '0;
    repeat (15) begin
      @(negedge clk);
      if (done) begin nd++; s1 = sum; end
    end
    chk("ign_done_count", 32'(nd), 32'd1);
    chk("ign_sum", 32'(s1), 32'h33);

    // Reset in the fourth RUN cycle aborts and clears the result.
    start = 1'b1; a = 8'hA5; b = 8'h3C;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    reset = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    run_add(8'h12, 8'h34, 1'b0, lat, nb);
    chk("post_abort_sum", 32'(sum), 32'h46);
    @(negedge clk);

    // Start held high: second request accepted in the DONE cycle.
    start = 1'b1; a = 8'h01; b = 8'h02; carryin = 1'b0;
    t1 = -1; t2 = -1; cyc = 0;
    while (t2 < 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc; s1 = sum; a = 8'h03; b = 8'h04;
        end else begin
          t2 = cyc; s2 = sum; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'd9);
    chk("b2b_sum1", 32'(s1), 32'h03);
    chk("b2b_sum2", 32'(s2), 32'h07);
    @(negedge clk);

    // Randomized traffic including occasional resets, checked by the model.
    repeat (600) begin
      @(negedge clk);
      start   = ($urandom_range(0, 2) == 0);
      a       = W'($urandom);
      b       = W'($urandom);
      carryin = 1'($urandom);
      reset   = ($urandom_range(0, 79) == 0);
    end
    reset = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. It shares one 1-bit full-adder stage across all bit positions of a WIDTH-bit addition, processing one bit per clock from LSB to MSB. It sits between a requester issuing start/operands and the 1-bit adder datapath, and returns a registered WIDTH-bit sum with a done pulse. It trades WIDTH cycles of latency for a single adder cell.

## Interface
- WIDTH, 8: operand and sum width in bits, ≥2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- carryin  input  1  carry into bit 0; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when sum/carryout are valid.
- sum  output  WIDTH  result, registered, held until next accepted start.
- carryout  output  1  carry out of bit WIDTH-1, registered, held.
- overflow  output  1  signed overflow flag (see Configuration).

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE.
- IDLE: busy=0. If start=1, capture a, b and carryin into the operand shift registers and the carry register, clear the bit counter and the result, and go to RUN.
- RUN: busy=1. Each cycle the full-adder stage adds the operand LSBs and the carry register. The sum bit shifts into the result MSB (the result shifts right). The carry register takes the stage carryout. The operands shift right and the counter increments. When the counter reaches WIDTH-1, that cycle's bit is the last, and the state goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle.
  - sum = result; carryout = final carry.
  - If start=1 in DONE, it is accepted exactly as in IDLE and the state goes to RUN (back-to-back). Otherwise the state goes to IDLE.
- start while busy=1 is ignored. No queuing.
- Operands are captured; changes on a/b/carryin after acceptance have no effect.
- Arithmetic: {carryout,sum} = a + b + carryin, modulo 2^(WIDTH+1). Never truncated.
- Reset mid-RUN aborts the operation. Next cycle: IDLE, busy=0, done=0, sum=0, carryout=0, overflow=0.

## Timing
- Reset values: busy=0, done=0, sum=0, carryout=0, overflow=0. Internal counter, carry and shift registers are cleared.
- start accepted at edge E0: busy=1 from E0 through E0+WIDTH (WIDTH cycles). done=1 in the cycle after edge E0+WIDTH. sum/carryout are valid from that same edge.
- Throughput: one addition per WIDTH+1 cycles, with start held or re-asserted in DONE.
- sum/carryout/overflow change only on the edge entering DONE, or on reset.

## Configuration
- SERIAL_ADDER_OVERFLOW_EN defined:
  - overflow is registered together with sum.
  - overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - It is held like sum.
- SERIAL_ADDER_OVERFLOW_EN undefined:
  - overflow is tied to 0.
  - No extra flop is built.
- The port exists in both cases.

## Structure
- Shared package serial_adder_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH constant;
  - counter width localparam, $clog2(WIDTH).
- One sub-module, serial_full_adder_bit: combinational 1-bit full adder (a, b, carryin -> sum, carryout). It is instantiated once; the controller is the only sequential logic.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, carryin=0, start pulse -> busy for 8 cycles, done on the 9th edge, sum=0x10, carryout=0.
- a=0xFF, b=0x01, carryin=0 -> sum=0x00, carryout=1, overflow=0. Then a=0xFF, b=0xFF, carryin=1 -> sum=0xFF, carryout=1.
- a=0x7F, b=0x01, carryin=0 -> sum=0x80, carryout=0. overflow=1 with SERIAL_ADDER_OVERFLOW_EN, 0 without.
- Start accepted, then start re-pulsed with new a/b at cycle 3 of RUN -> ignored. Result matches the first operands, and a single done pulse is seen.
- reset at cycle 4 of RUN -> next cycle busy=0, sum=0, no done. A subsequent start of 0x12+0x34 -> sum=0x46.
- start held high continuously with 0x01+0x02, then 0x03+0x04 presented in the DONE cycle -> done pulses separated by 9 cycles, sums 0x03 then 0x07.
